// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
//   Instruction-memory responder for the MIPS fetch stage. Word fetches are
//   accepted by PC byte address. They return in order after LATENCY cycles
//   through a small response FIFO. Credits (the outstanding count) make sure
//   every in-flight request already owns a FIFO slot, so fetch-stage stalls
//   can never overflow the FIFO.
// Ports
//   clock, reset        : sole clock; async active-low reset
//   load_en/addr/data   : memory fill port (blocks requests in the same cycle)
//   req_valid/ready     : fetch request handshake, req_addr = PC byte address
//   rsp_valid/ready     : response handshake from FIFO head
//   rsp_data/rsp_error  : instruction word (0 on error) and error flag
//   busy                : outstanding count is nonzero
module imem_fetch_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_error,
  output logic          busy
);

  localparam int STAGES = LATENCY - 1;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam logic [CW-1:0] FD = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } ent_t;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   diff, idx;
  logic          addr_err, acc, push, pop, full, empty;
  logic [CW-1:0] outst, wr_ptr, rd_ptr;
  logic [STAGES:0] vld_pipe;
  ent_t          pipe [LATENCY];
  ent_t          fifo [FIFO_DEPTH];
  ent_t          head;

  // Address decode: 32-bit wraparound difference; below-base addresses are
  // caught by the explicit compare since the difference wraps high.
  assign diff     = req_addr - BASE_ADDR;
  assign idx      = diff >> 2;
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                    (idx >= 32'(DEPTH_WORDS));

  // Credit check uses only registered outstanding, load_en and reset.
  assign req_ready = reset && !load_en && (outst < FD);
  assign acc       = req_valid && req_ready;

  // Memory has no reset; loads land at the edge, so a request accepted at
  // the following edge reads the new word.
  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  // Read pipeline: stage 0 captures at accept; the last stage pushes into
  // the FIFO at the next edge, giving LATENCY cycles to rsp_valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= acc;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (acc && addr_err) begin
      pipe[0].err  <= 1'b1;
      pipe[0].data <= '0;
    end else if (acc) begin
      pipe[0].err  <= 1'b0;
      pipe[0].data <= mem[idx[AW-1:0]];
    end
    for (int i = 1; i <= STAGES; i++) pipe[i] <= pipe[i-1];
  end

  // Response FIFO with one extra pointer bit to tell full from empty.
  assign push  = vld_pipe[STAGES];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr - rd_ptr) == FD);
  assign pop   = rsp_valid && rsp_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= pipe[STAGES];
  end

  assign head      = fifo[rd_ptr[PW-1:0]];
  assign rsp_valid = !empty;
  assign rsp_data  = rsp_valid ? head.data : '0;
  assign rsp_error = rsp_valid && head.err;

  // Outstanding covers pipeline plus FIFO occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) outst <= '0;
    else begin
      unique case ({acc, pop})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

  assign busy = (outst != '0);

  a_fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset) !(push && full));

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: random and directed fetches; a scoreboard
// queue of expected responses fed by the stimulus and drained by a monitor.
module tb_imem_fetch_responder;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int DW = 1024, LAT = 2, FD = 4;

  logic        clock = 0, reset = 0, load_en = 0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0, req_addr = '0;
  logic        req_valid = 0, req_ready, rsp_valid, rsp_ready, rsp_error, busy;
  logic [31:0] rsp_data;
  logic        rand_rdy = 0, rdy_rnd = 0, rdy_man = 0;

  assign rsp_ready = rand_rdy ? rdy_rnd : rdy_man;

  imem_fetch_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DW), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .busy(busy));

  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    bit          strict;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm [DW];
  int          checks = 0, fails = 0, accepts = 0;
  bit          strict_mode = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  // Reference: rules of the address map, straight arithmetic on the PC.
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    e.acc = 0; e.strict = 0;
    if ((a % 4) != 0 || a < BASE || ((a - BASE) / 4) >= DW) begin
      e.err = 1; e.data = 0;
    end else begin
      e.err = 0; e.data = mm[(a - BASE) / 4];
    end
    return e;
  endfunction

  // Called at posedge+1; holds the request until accepted, then returns at posedge+1.
  task automatic send(input logic [31:0] a);
    int n = 0;
    exp_t e;
    req_valid = 1; req_addr = a;
    @(negedge clock);
    while (!req_ready) begin
      n++;
      if (n > 100) begin
        chk(0, "req_accept_timeout", 0, 1);
        req_valid = 0;
        return;
      end
      @(negedge clock);
    end
    e = model(a); e.acc = cyc + 1; e.strict = strict_mode;
    sb.push_back(e);
    accepts++;
    @(posedge clock); #1;
    req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clock); n++; end
    repeat (2) @(posedge clock);
    #1;
    chk(sb.size() == 0, "drain_empty", sb.size(), 0);
    chk(busy == 0, "drain_busy", busy, 0);
  endtask

  initial begin
    fork
      begin : mon
        exp_t e;
        int lat;
        bit hold_v = 0;
        logic [31:0] hold_d = '0;
        logic hold_e = 0;
        forever begin
          @(negedge clock);
          if (!reset) hold_v = 0;
          else if (rsp_valid) begin
            if (hold_v) begin
              chk(rsp_data == hold_d, "hold_data", rsp_data, hold_d);
              chk(rsp_error == hold_e, "hold_err", rsp_error, hold_e);
            end
            if (rsp_ready) begin
              hold_v = 0;
              if (sb.size() == 0) chk(0, "unexpected_rsp", rsp_data, 0);
              else begin
                e = sb.pop_front();
                chk(rsp_data == e.data, "rsp_data", rsp_data, e.data);
                chk(rsp_error == e.err, "rsp_error", rsp_error, e.err);
                lat = cyc - e.acc;
                if (e.strict) chk(lat == LAT, "latency", 32'(lat), LAT);
                else          chk(lat >= LAT, "latency_min", 32'(lat), LAT);
              end
            end else begin
              hold_v = 1; hold_d = rsp_data; hold_e = rsp_error;
            end
          end else hold_v = 0;
        end
      end
      begin : rdy
        forever begin
          @(posedge clock); #1;
          rdy_rnd = 1'($urandom_range(0, 1));
        end
      end
      begin : tmo
        #1_000_000;
        chk(0, "global_timeout", 0, 0);
      end
      begin : stim
        logic [31:0] a;
        int r;
        // Reset with random inputs
        repeat (3) begin
          @(posedge clock); #1;
          req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom;
          load_en = 1'($urandom_range(0, 1)); load_addr = 10'($urandom); load_data = $urandom;
          rdy_man = 1'($urandom_range(0, 1));
          @(negedge clock);
          chk(rsp_valid == 0, "rst_rsp_valid", rsp_valid, 0);
          chk(rsp_data == 0, "rst_rsp_data", rsp_data, 0);
          chk(rsp_error == 0, "rst_rsp_error", rsp_error, 0);
          chk(busy == 0, "rst_busy", busy, 0);
          chk(req_ready == 0, "rst_req_ready", req_ready, 0);
        end
        @(posedge clock); #1;
        load_en = 0; req_valid = 0; rdy_man = 0; reset = 1;
        @(negedge clock);
        chk(req_ready == 1, "rel_req_ready", req_ready, 1);
        chk(busy == 0, "rel_busy", busy, 0);

        // Fill memory; words 0 and 1 are the directed program
        @(posedge clock); #1;
        for (int i = 0; i < DW; i++) begin
          load_en = 1; load_addr = 10'(i);
          load_data = (i == 0) ? 32'h3C01_1234 : (i == 1) ? 32'h3421_0001 : $urandom;
          mm[i] = load_data;
          @(posedge clock); #1;
        end
        load_en = 0;

        // Load then fetch, back-to-back, exact latency
        rdy_man = 1; strict_mode = 1;
        send(BASE); send(BASE + 4);
        strict_mode = 0;
        drain();

        // Backpressure: 4 credits
        rdy_man = 0; accepts = 0;
        for (int i = 0; i < 4; i++) send(BASE + 32'(4 * (10 + i)));
        req_valid = 1; req_addr = BASE + 32'(4 * 14);
        repeat (5) @(negedge clock);
        chk(accepts == 4, "bp_accepts", 32'(accepts), 4);
        chk(req_ready == 0, "bp_req_ready", req_ready, 0);
        chk(busy == 1, "bp_busy", busy, 1);
        @(posedge clock); #1;
        rdy_man = 1;
        send(BASE + 32'(4 * 14)); send(BASE + 32'(4 * 15));
        drain();
        chk(accepts == 6, "bp_total", 32'(accepts), 6);

        // Error addresses interleaved with a good fetch
        send(32'h0000_3002); send(32'h0000_2FFC); send(32'h0000_3008); send(32'h0000_4000);
        drain();

        // Load blocks a same-cycle request; next-cycle fetch sees new data
        load_en = 1; load_addr = 10'd5; load_data = 32'hDEAD_BEEF;
        req_valid = 1; req_addr = BASE + 20;
        @(negedge clock);
        chk(req_ready == 0, "load_blocks", req_ready, 0);
        mm[5] = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        load_en = 0; strict_mode = 1;
        send(BASE + 20);
        strict_mode = 0;
        drain();

        // Random traffic with random backpressure and idle-cycle loads
        rand_rdy = 1;
        repeat (200) begin
          r = $urandom_range(0, 9);
          if (r < 7)       a = BASE + 4 * $urandom_range(0, DW - 1);
          else if (r == 7) a = BASE + 4 * $urandom_range(0, DW - 1) + $urandom_range(1, 3);
          else if (r == 8) a = $urandom_range(0, BASE - 1);
          else             a = BASE + 4 * DW + 4 * $urandom_range(0, 1000);
          send(a);
          if ($urandom_range(0, 3) == 0) begin
            load_en = 1; load_addr = 10'($urandom); load_data = $urandom;
            mm[load_addr] = load_data;
            @(posedge clock); #1;
            load_en = 0;
          end
        end
        rand_rdy = 0; rdy_man = 1;
        drain();

        // Mid-operation reset drops in-flight work
        rdy_man = 0;
        send(BASE); send(BASE + 4); send(BASE + 8);
        reset = 0;
        sb.delete();
        @(negedge clock);
        chk(rsp_valid == 0, "mrst_rsp_valid", rsp_valid, 0);
        chk(busy == 0, "mrst_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1; rdy_man = 1;
        repeat (5) begin
          @(negedge clock);
          chk(rsp_valid == 0, "mrst_no_stale", rsp_valid, 0);
          chk(busy == 0, "mrst_idle", busy, 0);
        end
        @(posedge clock); #1;
        strict_mode = 1;
        send(BASE + 8);
        strict_mode = 0;
        drain();
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
